// File: rtl/gdc_pkg.sv
// rtl/gdc_pkg.sv - shared defaults and width helper for the credit FIFO slice
//
// Purpose : default data width and depth, plus the occupancy/credit counter
//           width derived from a depth (needs to hold the value DEPTH itself).
// Ports   : none (package).
package gdc_pkg;

  localparam int GDC_DATA_WIDTH = 16;
  localparam int GDC_DEPTH      = 8;

  // Counters run 0..DEPTH inclusive, hence DEPTH+1 states.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int GDC_CNT_W = cnt_width(GDC_DEPTH);

endpackage

// File: rtl/pipe_credit_fifo_credit_counter.sv
// rtl/pipe_credit_fifo_credit_counter.sv - issue credit counter with underflow flag
//
// Purpose : tracks how many words the source may still inject into the
//           fixed-latency pipeline. One credit per free FIFO slot not already
//           claimed by a word in flight.
// Ports   : clk, rst_n   clock, asynchronous active-low reset
//           issue        source injects a word this cycle
//           ret          a word left the FIFO this cycle (credit return)
//           credits      current credit count, 0..DEPTH
//           ok           credits available (issue will be accepted)
//           udf          sticky: issue seen while no credits were available
module credit_counter
  import gdc_pkg::*;
#(
  parameter int DEPTH = GDC_DEPTH,
  parameter int CW    = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue,
  input  logic          ret,
  output logic [CW-1:0] credits,
  output logic          ok,
  output logic          udf
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic take;

  assign ok   = (credits != '0);
  // An issue with no credits is not consumed; the return still counts.
  assign take = issue & ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits <= FULL;
      udf     <= 1'b0;
    end else begin
      if (take && !ret) begin
        credits <= credits - ONE;
      end else if (!take && ret && (credits != FULL)) begin
        // Saturate: returns for words that arrived without a credit
        // (e.g. in flight across a reset) must not push past DEPTH.
        credits <= credits + ONE;
      end
      if (issue && !ok) begin
        udf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_credit_fifo.sv
// rtl/pipe_credit_fifo.sv - credit-managed FIFO behind a fixed-latency pipeline
//
// Purpose : absorbs words from a pipeline that cannot be stalled. The source
//           spends a credit per injected word; credits come back as the
//           consumer drains the FIFO, so an obedient source never overflows
//           it whatever the pipeline latency.
// Ports   : clk, rst_n        clock, asynchronous active-low reset
//           i_issue           source injects a word this cycle
//           o_credit_ok       source may assert i_issue
//           i_valid, i_data   word arriving from the pipeline (push)
//           o_valid, o_data   show-ahead FIFO head
//           i_ready           consumer takes the head (pop when o_valid)
//           o_count           occupancy, o_credits current credits
//           o_ovf             sticky: arriving word dropped on full FIFO
//           o_udf             sticky: i_issue with zero credits
module pipe_credit_fifo
  import gdc_pkg::*;
#(
  parameter int DATA_WIDTH = GDC_DATA_WIDTH,
  parameter int DEPTH      = GDC_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_issue,
  output logic                         o_credit_ok,
  input  logic                         i_valid,
  input  logic [DATA_WIDTH-1:0]        i_data,
  output logic                         o_valid,
  output logic [DATA_WIDTH-1:0]        o_data,
  input  logic                         i_ready,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic [$clog2(DEPTH+1)-1:0]   o_credits,
  output logic                         o_ovf,
  output logic                         o_udf
);

  localparam int CW = cnt_width(DEPTH);
  localparam int PW = $clog2(DEPTH);

  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  ovf;

  logic push;
  logic pop;
  logic full;
  logic push_ok;

  assign push    = i_valid;
  assign pop     = o_valid & i_ready;
  assign full    = (count == CNT_FULL);
  // A pop frees the slot the same cycle, so a push on full is still taken.
  assign push_ok = push & (~full | pop);

  assign o_valid = (count != '0);
  assign o_data  = mem[rd_ptr];
  assign o_count = count;
  assign o_ovf   = ovf;

  // DEPTH is a power of two, so natural pointer wrap gives modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= i_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push_ok && !pop) begin
        count <= count + CNT_ONE;
      end else if (!push_ok && pop) begin
        count <= count - CNT_ONE;
      end
      if (push && !push_ok) begin
        ovf <= 1'b1;
      end
    end
  end

  credit_counter #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_credit (
    .clk     (clk),
    .rst_n   (rst_n),
    .issue   (i_issue),
    .ret     (pop),
    .credits (o_credits),
    .ok      (o_credit_ok),
    .udf     (o_udf)
  );

endmodule

// File: tb/tb_pipe_credit_fifo.sv
// tb/tb_pipe_credit_fifo.sv - scoreboard bench for pipe_credit_fifo
module tb_pipe_credit_fifo;
  import gdc_pkg::*;

  localparam int DW  = 16;
  localparam int DEP = 8;
  localparam int LAT = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 i_issue;
  logic                 o_credit_ok;
  logic                 i_valid;
  logic [DW-1:0]        i_data;
  logic                 o_valid;
  logic [DW-1:0]        o_data;
  logic                 i_ready;
  logic [GDC_CNT_W-1:0] o_count;
  logic [GDC_CNT_W-1:0] o_credits;
  logic                 o_ovf;
  logic                 o_udf;

  pipe_credit_fifo #(.DATA_WIDTH(DW), .DEPTH(DEP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_issue     (i_issue),
    .o_credit_ok (o_credit_ok),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .i_ready     (i_ready),
    .o_count     (o_count),
    .o_credits   (o_credits),
    .o_ovf       (o_ovf),
    .o_udf       (o_udf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: FIFO as a queue of words, credits as a plain integer.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  int            m_count;
  int            m_credits;
  bit            m_ovf;
  bit            m_udf;
  bit            inv_en;
  int            n_out;
  logic [DW-1:0] next_word;
  bit            line_v[$];
  logic [DW-1:0] line_d[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted head is compared against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && o_valid === 1'b1 && i_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_output: got %0h expected none", o_data);
        end else begin
          chk("data_order", 32'(o_data), 32'(exp_q.pop_front()));
          got_q.push_back(o_data);
          n_out++;
        end
      end
    end
  end

  task automatic check_state();
    int inflight;
    chk("count",     32'(o_count),     32'(m_count));
    chk("credits",   32'(o_credits),   32'(m_credits));
    chk("valid",     32'(o_valid),     32'(m_count != 0));
    chk("credit_ok", 32'(o_credit_ok), 32'(m_credits != 0));
    chk("ovf",       32'(o_ovf),       32'(m_ovf));
    chk("udf",       32'(o_udf),       32'(m_udf));
    if (m_count != 0 && exp_q.size() != 0) chk("head", 32'(o_data), 32'(exp_q[0]));
    if (inv_en) begin
      inflight = 0;
      foreach (line_v[k]) if (line_v[k]) inflight++;
      chk("conservation", 32'(int'(o_count) + int'(o_credits) + inflight), 32'(DEP));
    end
  endtask

  // One clock: check current state, drive inputs, advance the model.
  task automatic step(input bit iss, input bit rdy, input bit force_v,
                      input logic [DW-1:0] force_d, input bit inject);
    bit            v;
    logic [DW-1:0] d;
    bit            acc;
    bit            pop;
    bit            full;
    check_state();
    acc = iss && (m_credits != 0);
    v = line_v.pop_front();
    d = line_d.pop_front();
    if (force_v) begin
      v = 1'b1;
      d = force_d;
    end
    line_v.push_back(acc && inject);
    line_d.push_back(next_word);
    if (acc && inject) next_word++;
    i_issue = iss;
    i_ready = rdy;
    i_valid = v;
    i_data  = v ? d : DW'($urandom);
    pop  = (m_count != 0) && rdy;
    full = (m_count == DEP);
    if (v) begin
      if (!full || pop) begin
        exp_q.push_back(d);
        m_count++;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (pop) m_count--;
    if (iss && m_credits == 0) m_udf = 1'b1;
    m_credits = m_credits - int'(acc) + int'(pop);
    if (m_credits > DEP) m_credits = DEP;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit keep_line);
    i_issue = 1'b0;
    i_ready = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    rst_n   = 1'b0;
    #2;
    chk("rst_valid",     32'(o_valid),     32'd0);
    chk("rst_credit_ok", 32'(o_credit_ok), 32'd1);
    chk("rst_count",     32'(o_count),     32'd0);
    chk("rst_credits",   32'(o_credits),   32'(DEP));
    chk("rst_data",      32'(o_data),      32'd0);
    chk("rst_ovf",       32'(o_ovf),       32'd0);
    chk("rst_udf",       32'(o_udf),       32'd0);
    rst_n     = 1'b1;
    m_count   = 0;
    m_credits = DEP;
    m_ovf     = 1'b0;
    m_udf     = 1'b0;
    exp_q.delete();
    if (!keep_line) begin
      line_v.delete();
      line_d.delete();
      for (int k = 0; k < LAT; k++) begin
        line_v.push_back(1'b0);
        line_d.push_back('0);
      end
      next_word = 1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent;
    int cyc;
    bit iss;
    rst_n   = 1'b1;
    i_issue = 1'b0;
    i_ready = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    n_out   = 0;
    #3;
    do_reset(1'b0);
    inv_en = 1'b1;

    // Fill: 8 issues, words land two cycles later.
    for (int k = 0; k < DEP; k++) step(1, 0, 0, '0, 1);
    for (int k = 0; k < LAT; k++) step(0, 0, 0, '0, 1);
    chk("fill_credits",   32'(o_credits),   32'd0);
    chk("fill_credit_ok", 32'(o_credit_ok), 32'd0);
    chk("fill_count",     32'(o_count),     32'd8);
    chk("fill_ovf",       32'(o_ovf),       32'd0);

    // Drain in order.
    got_q.delete();
    for (int k = 0; k < DEP; k++) step(0, 1, 0, '0, 1);
    step(0, 0, 0, '0, 1);
    chk("drain_count",   32'(o_count),   32'd0);
    chk("drain_credits", 32'(o_credits), 32'd8);
    chk("drain_n",       32'(got_q.size()), 32'd8);
    for (int k = 0; k < got_q.size() && k < DEP; k++)
      chk("drain_seq", 32'(got_q[k]), 32'(k + 1));

    // Refill, then a push and pop together while full.
    for (int k = 0; k < DEP; k++) step(1, 0, 0, '0, 1);
    for (int k = 0; k < LAT; k++) step(0, 0, 0, '0, 1);
    inv_en = 1'b0;
    step(0, 1, 1, 16'hABCD, 1);
    step(0, 0, 0, '0, 1);
    chk("pushpop_count", 32'(o_count), 32'd8);
    chk("pushpop_ovf",   32'(o_ovf),   32'd0);

    // Forced arrival on full with no pop: dropped and sticky.
    step(0, 0, 1, 16'hDEAD, 1);
    chk("ovf_set",   32'(o_ovf),   32'd1);
    chk("ovf_count", 32'(o_count), 32'd8);
    for (int k = 0; k < 3; k++) step(0, 0, 0, '0, 1);
    chk("ovf_held", 32'(o_ovf), 32'd1);

    // Underflow: spend the last credit, then issue with none.
    step(1, 0, 0, '0, 0);
    chk("udf_pre_credits", 32'(o_credits), 32'd0);
    step(1, 0, 0, '0, 0);
    chk("udf_set",     32'(o_udf),     32'd1);
    chk("udf_credits", 32'(o_credits), 32'd0);
    step(1, 1, 0, '0, 0);
    chk("udf_pop_credits", 32'(o_credits), 32'd1);
    step(0, 0, 0, '0, 0);

    do_reset(1'b0);
    chk("post_rst_ovf", 32'(o_ovf), 32'd0);
    chk("post_rst_udf", 32'(o_udf), 32'd0);

    // 20 words streaming, random issue and ready, pointers wrap.
    inv_en = 1'b1;
    n_out  = 0;
    sent   = 0;
    cyc    = 0;
    while (n_out < 20 && cyc < 600) begin
      iss = (sent < 20) && (m_credits != 0) && ($urandom_range(3) != 0);
      if (iss) sent++;
      step(iss, 1'($urandom), 0, '0, 1);
      cyc++;
    end
    chk("stream_done", 32'(n_out), 32'd20);
    chk("stream_left", 32'(exp_q.size()), 32'd0);

    // Mid-operation reset with words still in flight.
    for (int k = 0; k < 12; k++) step(1'($urandom), 1'($urandom), 0, '0, 1);
    step(1, 1, 0, '0, 1);
    step(1, 1, 0, '0, 1);
    do_reset(1'b1);
    inv_en = 1'b0;
    for (int k = 0; k < 15; k++) step(0, 1, 0, '0, 1);
    chk("midrst_count",   32'(o_count),   32'd0);
    chk("midrst_credits", 32'(o_credits), 32'd8);
    chk("midrst_left",    32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
